// File: rtl/svm_hwf_pkg.sv
// Shared types and fixed-point constants for the SVM kernel-vector datapath.
// Products are Q0.15; kernel outputs are sign-magnitude 8.8.
package svm_hwf_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACCUM   = 3'd1,
    FINISH  = 3'd2,
    CONVERT = 3'd3,
    SEND    = 3'd4
  } state_t;

  localparam int PROD_FRAC = 15;
  localparam int OUT_FRAC  = 8;
  localparam int SHIFT     = PROD_FRAC - OUT_FRAC;
  localparam int OUT_W     = 2 * OUT_FRAC;
  localparam int MAG_W     = OUT_W - 1;

  localparam logic [MAG_W-1:0] SAT_MAG = 15'h7FFF;

endpackage

// File: rtl/kernel_sm_convert.sv
// Combinational conversion of one signed Q.15 accumulator into sign-magnitude 8.8
// with magnitude saturation; a zero magnitude never carries a sign bit.
module kernel_sm_convert
  import svm_hwf_pkg::*;
#(
  parameter int ACC_WIDTH = 26
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  output logic        [OUT_W-1:0]     sm
);

  logic                 neg;
  logic [ACC_WIDTH-1:0] abs_val;
  logic [ACC_WIDTH-1:0] shifted;
  logic [MAG_W-1:0]     mag;

  always_comb begin
    neg     = acc[ACC_WIDTH-1];
    abs_val = neg ? ($unsigned(~acc) + ACC_WIDTH'(1)) : $unsigned(acc);
    // Truncating shift drops the extra fraction bits of Q.15 to reach Q.8.
    shifted = abs_val >> SHIFT;
    if (shifted > ACC_WIDTH'(SAT_MAG)) begin
      mag = SAT_MAG;
    end else begin
      mag = shifted[MAG_W-1:0];
    end
    sm = {neg && (mag != '0), mag};
  end

endmodule

// File: rtl/kernel_vector_gen_hwf.sv
// Streams one image, accumulates a linear kernel against every support vector
// in parallel, converts to sign-magnitude 8.8 and drives the decision-function enable window.
module kernel_vector_gen_hwf
  import svm_hwf_pkg::*;
#(
  parameter int XLEN_PIXEL    = 8,
  parameter int NUM_OF_PIXELS = 784,
  parameter int NUM_OF_SV     = 10,
  parameter int ACC_WIDTH     = 26
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic [XLEN_PIXEL-1:0]                 pix_data,
  input  logic                                  pix_valid,
  output logic                                  pix_ready,
  output logic [$clog2(NUM_OF_PIXELS)-1:0]      sv_addr,
  input  logic [XLEN_PIXEL*NUM_OF_SV-1:0]       sv_rdata,
  output logic [2*XLEN_PIXEL*NUM_OF_SV-1:0]     kernel_out,
  output logic                                  decision_funct_en,
  output logic                                  busy,
  output logic                                  frame_done
);

  localparam int CNT_W  = $clog2(NUM_OF_PIXELS);
  localparam int SEND_W = (NUM_OF_SV > 1) ? $clog2(NUM_OF_SV) : 1;
  localparam int PROD_W = 2 * XLEN_PIXEL - 1;

  localparam logic [CNT_W-1:0]  LAST_PIX  = CNT_W'(NUM_OF_PIXELS - 1);
  localparam logic [SEND_W-1:0] LAST_SEND = SEND_W'(NUM_OF_SV - 1);

  // Handshake: a pixel transfers on any rising clk edge where pix_valid && pix_ready;
  // pix_valid may drop at will, and pix_ready is high exactly while in ACCUM.

  state_t              state, state_next;
  logic [SEND_W-1:0]   send_cnt, send_cnt_next;
  logic [CNT_W-1:0]    pix_cnt;
  logic                hs;
  logic                start_frame;
  logic                s1_valid;
  logic [XLEN_PIXEL-1:0] s1_pix;
  logic [OUT_W*NUM_OF_SV-1:0] conv_bus;

  assign hs          = pix_valid && pix_ready;
  assign start_frame = (state == IDLE) && start;

  always_comb begin
    state_next    = state;
    send_cnt_next = send_cnt;
    case (state)
      IDLE:    if (start) state_next = ACCUM;
      ACCUM:   if (hs && (pix_cnt == LAST_PIX)) state_next = FINISH;
      FINISH:  state_next = CONVERT;
      CONVERT: begin
        state_next    = SEND;
        send_cnt_next = '0;
      end
      SEND: begin
        if (send_cnt == LAST_SEND) begin
          state_next = IDLE;
        end else begin
          send_cnt_next = send_cnt + SEND_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Status outputs are registered from the next-state decode so they line up with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      send_cnt          <= '0;
      pix_ready         <= 1'b0;
      busy              <= 1'b0;
      decision_funct_en <= 1'b0;
      frame_done        <= 1'b0;
    end else begin
      state             <= state_next;
      send_cnt          <= send_cnt_next;
      pix_ready         <= (state_next == ACCUM);
      busy              <= (state_next != IDLE);
      decision_funct_en <= (state_next == SEND);
      frame_done        <= (state_next == SEND) && (send_cnt_next == LAST_SEND);
    end
  end

  // sv_addr doubles as the SV memory's address register, so the weights for a pixel
  // arrive in the cycle after its handshake, alongside the registered pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt  <= '0;
      sv_addr  <= '0;
      s1_pix   <= '0;
      s1_valid <= 1'b0;
    end else if (start_frame) begin
      pix_cnt  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= hs;
      if (hs) begin
        pix_cnt <= pix_cnt + CNT_W'(1);
        sv_addr <= pix_cnt;
        s1_pix  <= pix_data;
      end
    end
  end

  for (genvar i = 0; i < NUM_OF_SV; i++) begin : g_lane
    logic [XLEN_PIXEL-1:0]       w;
    logic [PROD_W-1:0]           prod;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] acc;

    assign w        = sv_rdata[XLEN_PIXEL*i +: XLEN_PIXEL];
    assign prod     = PROD_W'(s1_pix) * PROD_W'(w[XLEN_PIXEL-2:0]);
    assign prod_ext = signed'(ACC_WIDTH'(prod));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc <= '0;
      end else if (start_frame) begin
        acc <= '0;
      end else if (s1_valid) begin
        acc <= w[XLEN_PIXEL-1] ? (acc - prod_ext) : (acc + prod_ext);
      end
    end

    kernel_sm_convert #(
      .ACC_WIDTH(ACC_WIDTH)
    ) u_conv (
      .acc(acc),
      .sm (conv_bus[OUT_W*i +: OUT_W])
    );
  end

  // kernel_out is only rewritten in CONVERT; start does not clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kernel_out <= '0;
    end else if (state == CONVERT) begin
      kernel_out <= conv_bus;
    end
  end

endmodule

// File: tb/tb_kernel_vector_gen_hwf.sv
// Scoreboard bench for kernel_vector_gen_hwf: arithmetic reference model per frame,
// driver with optional valid gaps and start spam, monitor checking the enable window.
module tb_kernel_vector_gen_hwf;

  localparam int NP = 784;
  localparam int NS = 10;
  localparam int AW = 10;
  localparam int KW = 16 * NS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    pix_data = 8'h00;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic [AW-1:0] sv_addr;
  logic [8*NS-1:0] sv_rdata;
  logic [KW-1:0] kernel_out;
  logic          decision_funct_en;
  logic          busy;
  logic          frame_done;

  kernel_vector_gen_hwf dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .pix_data         (pix_data),
    .pix_valid        (pix_valid),
    .pix_ready        (pix_ready),
    .sv_addr          (sv_addr),
    .sv_rdata         (sv_rdata),
    .kernel_out       (kernel_out),
    .decision_funct_en(decision_funct_en),
    .busy             (busy),
    .frame_done       (frame_done)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- image and SV memory ----------------
  logic [7:0] pix_mem [NP];
  logic [7:0] w_mem   [NP][NS];

  always_comb begin
    sv_rdata = '0;
    for (int i = 0; i < NS; i++) begin
      if (int'(sv_addr) < NP) sv_rdata[8*i +: 8] = w_mem[sv_addr][i];
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [KW-1:0] exp_q[$];
  int            rise_q[$];
  logic [KW-1:0] last_kout = '0;
  logic [KW-1:0] cur_exp = '0;

  task automatic check_int(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_bus(input string name, input logic [KW-1:0] act, input logic [KW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: exact signed dot product per lane, then |x|/128 floor, clamp, sign-magnitude.
  function automatic logic [KW-1:0] model();
    logic [KW-1:0] r;
    longint s, p, m;
    r = '0;
    for (int lane = 0; lane < NS; lane++) begin
      s = 0;
      for (int idx = 0; idx < NP; idx++) begin
        p = longint'(pix_mem[idx]) * longint'(w_mem[idx][lane][6:0]);
        if (w_mem[idx][lane][7]) s = s - p;
        else s = s + p;
      end
      m = ((s < 0) ? -s : s) / 128;
      if (m > 32767) m = 32767;
      r[16*lane +: 16] = {(s < 0) && (m != 0), m[14:0]};
    end
    return r;
  endfunction

  task automatic fill(input int mode);
    for (int idx = 0; idx < NP; idx++) begin
      case (mode)
        0: pix_mem[idx] = 8'h10;
        2, 3: pix_mem[idx] = 8'hFF;
        4: pix_mem[idx] = 8'h10;
        default: pix_mem[idx] = 8'($urandom_range(0, 255));
      endcase
      for (int lane = 0; lane < NS; lane++) begin
        case (mode)
          0: w_mem[idx][lane] = 8'h40;
          1: w_mem[idx][lane] = (lane == 1) ? 8'hC0 : ((lane == 2) ? 8'h00 : 8'h40);
          2: w_mem[idx][lane] = 8'h7F;
          3: w_mem[idx][lane] = 8'hFF;
          4: w_mem[idx][lane] = (idx % 2 == 0) ? 8'h40 : 8'hC0;
          default: w_mem[idx][lane] = 8'($urandom_range(0, 255));
        endcase
      end
      if (mode == 1) pix_mem[idx] = 8'h10;
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_frame(input bit stall, input bit spam, input int abort_at);
    int idx, budget, t_last, t_cur;
    bit hs;
    logic [KW-1:0] e;
    e = '0;
    t_last = 0;
    if (abort_at < 0) begin
      e = model();
      exp_q.push_back(e);
    end
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check_int("ready_in_accum", longint'(pix_ready), 1);
    check_int("busy_in_accum", longint'(busy), 1);
    check_bus("kernel_out_held_across_start", kernel_out, last_kout);
    idx = 0;
    budget = 0;
    while (idx < NP && budget < 5000) begin
      if (abort_at >= 0 && idx == abort_at) break;
      pix_valid = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      pix_data  = pix_valid ? pix_mem[idx] : 8'($urandom_range(0, 255));
      start     = spam ? ($urandom_range(0, 3) == 0) : 1'b0;
      hs        = pix_valid && pix_ready;
      t_cur     = cyc;
      @(posedge clk); #1;
      if (hs) begin
        idx++;
        t_last = t_cur;
      end
      budget++;
    end
    pix_valid = 1'b0;
    start     = 1'b0;
    if (abort_at >= 0) return;
    check_int("all_pixels_accepted", longint'(idx), NP);
    rise_q.push_back(t_last + 3);
    last_kout = e;
    budget = 0;
    while (busy && budget < 100) begin
      start = spam;
      @(posedge clk); #1;
      budget++;
    end
    start = 1'b0;
    check_int("frame_ends_in_budget", longint'(busy), 0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check_int("stays_idle_after_frame", longint'(busy), 0);
  endtask

  task automatic check_reset_outputs();
    check_int("rst_pix_ready", longint'(pix_ready), 0);
    check_int("rst_sv_addr", longint'(sv_addr), 0);
    check_bus("rst_kernel_out", kernel_out, '0);
    check_int("rst_en", longint'(decision_funct_en), 0);
    check_int("rst_busy", longint'(busy), 0);
    check_int("rst_frame_done", longint'(frame_done), 0);
  endtask

  // ---------------- monitor ----------------
  int run = 0;
  int fd_cnt = 0;
  bit prev_en = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      run     = 0;
      fd_cnt  = 0;
      prev_en = 1'b0;
    end else begin
      if (decision_funct_en && !prev_en) begin
        run = 1;
        if (exp_q.size() == 0) begin
          check_int("frames_pending_at_en_rise", longint'(exp_q.size()), 1);
        end else begin
          cur_exp = exp_q.pop_front();
          check_bus("kernel_out_at_en_rise", kernel_out, cur_exp);
          check_int("en_rise_cycle", longint'(cyc),
                    (rise_q.size() != 0) ? longint'(rise_q.pop_front()) : -1);
        end
      end else if (decision_funct_en) begin
        run++;
        check_bus("kernel_out_stable_in_window", kernel_out, cur_exp);
      end
      if (frame_done) begin
        fd_cnt++;
        check_int("frame_done_with_en", longint'(decision_funct_en), 1);
        check_int("frame_done_on_last_en", longint'(run), NS);
      end
      if (!decision_funct_en && prev_en) begin
        check_int("en_window_length", longint'(run), NS);
        check_int("frame_done_pulses", longint'(fd_cnt), 1);
        fd_cnt = 0;
      end
      prev_en = decision_funct_en;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;

    fill(0); run_frame(1'b0, 1'b0, -1);
    fill(1); run_frame(1'b0, 1'b0, -1);
    fill(2); run_frame(1'b0, 1'b0, -1);
    fill(3); run_frame(1'b0, 1'b0, -1);
    fill(4); run_frame(1'b0, 1'b0, -1);
    fill(0); run_frame(1'b1, 1'b1, -1);
    fill(5); run_frame(1'b1, 1'b1, -1);

    fill(0);
    run_frame(1'b0, 1'b0, 300);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    last_kout = '0;
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    run_frame(1'b0, 1'b0, -1);

    repeat (5) @(posedge clk);
    check_int("no_frames_left_unchecked", longint'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
